// File: rtl/benes_route_ctrl.sv
// Sequenced routing controller for an 8-port Benes network.
// Validates a destination permutation, then derives all 20 switch settings
// with the looping algorithm (lowest unset switch first, straight first):
// 8 check cycles, 4 outer-loop cycles, 2 inner cycles, then a held output.
module benes_route_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] perm_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [19:0] cfg,
  output logic        err,
  output logic        cfg_valid,
  input  logic        cfg_ready
);

  typedef enum logic [2:0] {StIdle, StCheck, StOuter, StInner, StDone} state_e;

  state_e          state_q, state_d;
  logic [7:0][2:0] mp_q, mp_d;
  logic [7:0][2:0] inv_q, inv_d;
  logic [7:0]      seen_q, seen_d;
  logic            dup_q, dup_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [3:0]      s0set_q, s0set_d;
  logic [2:0]      nxt_q, nxt_d;
  logic [3:0][1:0] up_q, up_d;
  logic [3:0][1:0] lo_q, lo_d;
  logic [19:0]     cfg_q, cfg_d;
  logic            err_q, err_d;

  // Check stage: destination under test and running duplicate flag
  logic [2:0] chk_dst;
  logic       dup_now;
  assign chk_dst = mp_q[cnt_q];
  assign dup_now = dup_q | seen_q[chk_dst];

  // Outer loop: input routed to the upper subnet this cycle, and its partner's destination
  logic [1:0] low_k;
  logic [2:0] oc;
  logic [2:0] od;

  // Lowest stage-0 switch not yet set
  always_comb begin
    low_k = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (!s0set_q[k]) low_k = 2'(k);
    end
  end

  // Continue the open loop unless it has closed onto an already-set switch
  assign oc = s0set_q[nxt_q[2:1]] ? {low_k, 1'b0} : nxt_q;
  assign od = mp_q[oc ^ 3'd1];

  // Inner 4x4 routing for both subnets: port 0 always goes straight/up first
  logic [1:0][3:0][1:0] sp;
  logic [1:0][3:0][1:0] sinv;
  logic [1:0][1:0]      d1, j1, c2, d2;

  // Per-subnet looping decisions derived from the recorded sub-permutations
  always_comb begin
    sp   = '0;
    sinv = '0;
    d1   = '0;
    j1   = '0;
    c2   = '0;
    d2   = '0;
    for (int h = 0; h < 2; h++) begin
      sp[h] = (h == 0) ? up_q : lo_q;
      for (int q = 0; q < 4; q++) sinv[h][sp[h][q]] = 2'(q);
      d1[h] = sp[h][1];
      j1[h] = sinv[h][d1[h] ^ 2'd1];
      // Loop closed on switch 0 -> start fresh at port 2
      c2[h] = j1[h][1] ? j1[h] : 2'd2;
      d2[h] = sp[h][c2[h] ^ 2'd1];
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StCheck;
      StCheck: if (cnt_q == 3'd7) state_d = dup_now ? StDone : StOuter;
      StOuter: if (cnt_q == 3'd3) state_d = StInner;
      StInner: if (cnt_q == 3'd1) state_d = StDone;
      StDone:  if (cfg_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath updates for each phase of the routing job
  always_comb begin
    mp_d    = mp_q;
    inv_d   = inv_q;
    seen_d  = seen_q;
    dup_d   = dup_q;
    cnt_d   = cnt_q;
    s0set_d = s0set_q;
    nxt_d   = nxt_q;
    up_d    = up_q;
    lo_d    = lo_q;
    cfg_d   = cfg_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          mp_d    = perm_in;
          seen_d  = '0;
          dup_d   = 1'b0;
          cnt_d   = '0;
          s0set_d = '0;
          nxt_d   = '0;
          cfg_d   = '0;
          err_d   = 1'b0;
        end
      end
      StCheck: begin
        dup_d           = dup_now;
        seen_d[chk_dst] = 1'b1;
        inv_d[chk_dst]  = cnt_q;
        cnt_d           = cnt_q + 3'd1;
        if (cnt_q == 3'd7) err_d = dup_now;
      end
      StOuter: begin
        s0set_d[oc[2:1]]         = 1'b1;
        cfg_d[{3'b000, oc[2:1]}] = oc[0];
        up_d[oc[2:1]]            = mp_q[oc][2:1];
        lo_d[oc[2:1]]            = od[2:1];
        // Partner exits via the lower subnet, fixing its stage-4 switch
        cfg_d[{3'b100, od[2:1]}] = ~od[0];
        nxt_d                    = inv_q[od ^ 3'd1];
        cnt_d                    = (cnt_q == 3'd3) ? 3'd0 : cnt_q + 3'd1;
      end
      StInner: begin
        for (int h = 0; h < 2; h++) begin
          if (cnt_q == 3'd0) begin
            cfg_d[{3'b011, 1'(h), d1[h][1]}] = ~d1[h][0];
          end else begin
            cfg_d[{3'b001, 1'(h), 1'b1}]     = c2[h][0];
            cfg_d[{3'b011, 1'(h), d2[h][1]}] = ~d2[h][0];
            cfg_d[{3'b010, 1'(h), 1'b0}]     = sp[h][0][1];
            cfg_d[{3'b010, 1'(h), 1'b1}]     = sp[h][1][1];
          end
        end
        cnt_d = cnt_q + 3'd1;
      end
      StDone: ;
      default: ;
    endcase
  end

  // Handshake and result outputs
  always_comb begin
    in_ready  = (state_q == StIdle);
    cfg_valid = (state_q == StDone);
    cfg       = cfg_q;
    err       = err_q;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mp_q    <= '0;
      inv_q   <= '0;
      seen_q  <= '0;
      dup_q   <= 1'b0;
      cnt_q   <= '0;
      s0set_q <= '0;
      nxt_q   <= '0;
      up_q    <= '0;
      lo_q    <= '0;
      cfg_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      mp_q    <= mp_d;
      inv_q   <= inv_d;
      seen_q  <= seen_d;
      dup_q   <= dup_d;
      cnt_q   <= cnt_d;
      s0set_q <= s0set_d;
      nxt_q   <= nxt_d;
      up_q    <= up_d;
      lo_q    <= lo_d;
      cfg_q   <= cfg_d;
      err_q   <= err_d;
    end
  end

endmodule
